// File: rtl/id_stage.sv
// ARM decode stage: 15-entry register file, control decode, condition check
// and the ID/EX pipeline register feeding EXE.
module id_stage #(
  parameter int NUM_REGS       = 15,
  parameter bit REG_RESET_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  input  logic        wb_en_in,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b,
  output logic        s,
  output logic        imm,
  output logic [3:0]  exe_cmd,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  id_src1,
  output logic [3:0]  id_src2
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        br;
    logic        set_s;
    logic        imm;
    logic [3:0]  cmd;
    logic [11:0] shift_op;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } idex_t;

  idex_t idex_q, idex_d;

  logic [3:0] cond, opcode;
  logic [1:0] mode;
  logic       i_bit, s_bit, is_str;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign i_bit  = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign is_str = (mode == 2'b01) & ~s_bit;

  // STR reads Rd as its store data, so it goes out on the second read port
  assign src1    = instruction[19:16];
  assign src2    = is_str ? instruction[15:12] : instruction[3:0];
  assign two_src = (~i_bit & (mode == 2'b00)) | is_str;

  // Register file: R15 is not stored and always reads 0
  logic [31:0]      rf_q [NUM_REGS];
  logic [1:0][3:0]  rd_addr;
  logic [1:0][31:0] rd_data;

  assign rd_addr = {src2, src1};

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_addr[p] != 4'd15) begin
        if (wb_en_in && wb_dest == rd_addr[p]) rd_data[p] = wb_value;
        else if (int'(rd_addr[p]) < NUM_REGS) rd_data[p] = rf_q[rd_addr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= REG_RESET_INIT ? 32'(i) : 32'd0;
    end else if (wb_en_in && !freeze && wb_dest != 4'd15) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wb_dest == 4'(i)) rf_q[i] <= wb_value;
    end
  end

  // Control unit
  logic [3:0] c_cmd;
  logic       c_wb, c_mr, c_mw, c_b, c_s;

  always_comb begin
    c_cmd = 4'd0;
    c_wb  = 1'b0;
    c_mr  = 1'b0;
    c_mw  = 1'b0;
    c_b   = 1'b0;
    c_s   = 1'b0;
    case (mode)
      2'b00: begin
        c_wb = 1'b1;
        c_s  = s_bit;
        case (opcode)
          4'b1101: c_cmd = 4'b0001;
          4'b1111: c_cmd = 4'b1001;
          4'b0100: c_cmd = 4'b0010;
          4'b0101: c_cmd = 4'b0011;
          4'b0010: c_cmd = 4'b0100;
          4'b0110: c_cmd = 4'b0101;
          4'b0000: c_cmd = 4'b0110;
          4'b1100: c_cmd = 4'b0111;
          4'b0001: c_cmd = 4'b1000;
          4'b1010: begin c_cmd = 4'b0100; c_wb = 1'b0; end
          4'b1000: begin c_cmd = 4'b0110; c_wb = 1'b0; end
          default: begin c_wb = 1'b0; c_s = 1'b0; end
        endcase
      end
      2'b01: begin
        c_cmd = 4'b0010;
        c_s   = s_bit;
        c_mr  = s_bit;
        c_wb  = s_bit;
        c_mw  = ~s_bit;
      end
      2'b10:   c_b = 1'b1;
      default: ;
    endcase
  end

  // Condition check against {N,Z,C,V}
  logic st_n, st_z, st_c, st_v, cond_ok;
  assign {st_n, st_z, st_c, st_v} = status;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = st_z;
      4'h1: cond_ok = ~st_z;
      4'h2: cond_ok = st_c;
      4'h3: cond_ok = ~st_c;
      4'h4: cond_ok = st_n;
      4'h5: cond_ok = ~st_n;
      4'h6: cond_ok = st_v;
      4'h7: cond_ok = ~st_v;
      4'h8: cond_ok = st_c & ~st_z;
      4'h9: cond_ok = ~st_c | st_z;
      4'hA: cond_ok = (st_n == st_v);
      4'hB: cond_ok = (st_n != st_v);
      4'hC: cond_ok = ~st_z & (st_n == st_v);
      4'hD: cond_ok = st_z | (st_n != st_v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // ID/EX next state; data fields are captured even when control is bubbled
  always_comb begin
    idex_d = '0;
    if (!flush) begin
      idex_d.pc       = pc_in;
      idex_d.rn       = rd_data[0];
      idex_d.rm       = rd_data[1];
      idex_d.imm      = i_bit;
      idex_d.shift_op = instruction[11:0];
      idex_d.simm     = instruction[23:0];
      idex_d.dest     = instruction[15:12];
      idex_d.src1     = src1;
      idex_d.src2     = src2;
      if (cond_ok && !hazard) begin
        idex_d.wb_en = c_wb;
        idex_d.mem_r = c_mr;
        idex_d.mem_w = c_mw;
        idex_d.br    = c_b;
        idex_d.set_s = c_s;
        idex_d.cmd   = c_cmd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)        idex_q <= '0;
    else if (!freeze) idex_q <= idex_d;
  end

  assign pc_out        = idex_q.pc;
  assign val_rn        = idex_q.rn;
  assign val_rm        = idex_q.rm;
  assign wb_en         = idex_q.wb_en;
  assign mem_r_en      = idex_q.mem_r;
  assign mem_w_en      = idex_q.mem_w;
  assign b             = idex_q.br;
  assign s             = idex_q.set_s;
  assign imm           = idex_q.imm;
  assign exe_cmd       = idex_q.cmd;
  assign shift_operand = idex_q.shift_op;
  assign signed_imm_24 = idex_q.simm;
  assign dest          = idex_q.dest;
  assign id_src1       = idex_q.src1;
  assign id_src2       = idex_q.src2;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a table-driven reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0, freeze = 1'b0, flush = 1'b0, hazard = 1'b0;
  logic [31:0] pc_in = '0, instruction = '0;
  logic [3:0]  status = '0;
  logic        wb_en_in = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [31:0] wb_value = '0;

  logic [3:0]  src1, src2, exe_cmd, dest, id_src1, id_src2;
  logic        two_src, wb_en, mem_r_en, mem_w_en, b, s, imm;
  logic [31:0] pc_out, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  id_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .pc_in(pc_in), .instruction(instruction), .status(status),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .src1(src1), .src2(src2), .two_src(two_src),
    .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
    .exe_cmd(exe_cmd), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .id_src1(id_src1), .id_src2(id_src2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  alu_cmd [16];
  bit          alu_wb  [16];
  bit          alu_ok  [16];
  logic [31:0] m_regs  [15];

  logic [31:0] e_pc, e_rn, e_rm;
  logic        e_wb, e_mr, e_mw, e_b, e_s, e_imm;
  logic [3:0]  e_cmd, e_dest, e_s1, e_s2;
  logic [11:0] e_sh;
  logic [23:0] e_si;

  task automatic def_op(input logic [3:0] op, input logic [3:0] cmd, input bit wbv);
    alu_ok[op] = 1'b1; alu_cmd[op] = cmd; alu_wb[op] = wbv;
  endtask

  // Conditions come in complementary pairs: the low bit inverts the base test
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cc, v;
    logic [7:0] base;
    {n, z, cc, v} = st;
    base = {1'b1, ~z & (n == v), n == v, cc & ~z, v, n, cc, z};
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return base[c[3:1]] ^ c[0];
  endfunction

  function automatic bit m_is_str(input logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  function automatic logic [3:0] m_src2(input logic [31:0] ins);
    return m_is_str(ins) ? ins[15:12] : ins[3:0];
  endfunction

  function automatic bit m_two_src(input logic [31:0] ins);
    return (ins[27:26] == 2'b00 && !ins[25]) || m_is_str(ins);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return 32'd0;
    if (wb_en_in && wb_dest == a) return wb_value;
    return m_regs[a];
  endfunction

  task automatic zero_exp();
    {e_pc, e_rn, e_rm, e_wb, e_mr, e_mw, e_b, e_s, e_imm} = '0;
    {e_cmd, e_dest, e_s1, e_s2, e_sh, e_si} = '0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      zero_exp();
      for (int i = 0; i < 15; i++) m_regs[i] = 32'(i);
    end else if (!freeze) begin
      if (flush) zero_exp();
      else begin
        e_pc   = pc_in;
        e_rn   = m_read(instruction[19:16]);
        e_rm   = m_read(m_src2(instruction));
        e_imm  = instruction[25];
        e_sh   = instruction[11:0];
        e_si   = instruction[23:0];
        e_dest = instruction[15:12];
        e_s1   = instruction[19:16];
        e_s2   = m_src2(instruction);
        {e_wb, e_mr, e_mw, e_b, e_s, e_cmd} = '0;
        case (instruction[27:26])
          2'b00: if (alu_ok[instruction[24:21]]) begin
                   e_cmd = alu_cmd[instruction[24:21]];
                   e_wb  = alu_wb[instruction[24:21]];
                   e_s   = instruction[20];
                 end
          2'b01: begin
                   e_cmd = 4'b0010;
                   e_s   = instruction[20];
                   e_mr  = instruction[20];
                   e_wb  = instruction[20];
                   e_mw  = !instruction[20];
                 end
          2'b10: e_b = 1'b1;
          default: ;
        endcase
        if (hazard || !cond_true(instruction[31:28], status))
          {e_wb, e_mr, e_mw, e_b, e_s, e_cmd} = '0;
      end
      if (wb_en_in && wb_dest != 4'd15) m_regs[wb_dest] = wb_value;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 160'({wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd}),
                    160'({e_wb, e_mr, e_mw, e_b, e_s, e_imm, e_cmd}));
      check("data", 160'({pc_out, val_rn, val_rm}), 160'({e_pc, e_rn, e_rm}));
      check("fields", 160'({shift_operand, signed_imm_24, dest, id_src1, id_src2}),
                      160'({e_sh, e_si, e_dest, e_s1, e_s2}));
      check("comb", 160'({src1, src2, two_src}),
                    160'({instruction[19:16], m_src2(instruction), m_two_src(instruction)}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instruction = ins;
    pc_in       = pc;
  endtask

  function automatic logic [159:0] all_regd();
    return {pc_out, val_rn, val_rm, wb_en, mem_r_en, mem_w_en, b, s, imm,
            exe_cmd, shift_operand, signed_imm_24, dest, id_src1, id_src2};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin alu_ok[i] = 1'b0; alu_cmd[i] = '0; alu_wb[i] = 1'b0; end
    def_op(4'b1101, 4'b0001, 1'b1);
    def_op(4'b1111, 4'b1001, 1'b1);
    def_op(4'b0100, 4'b0010, 1'b1);
    def_op(4'b0101, 4'b0011, 1'b1);
    def_op(4'b0010, 4'b0100, 1'b1);
    def_op(4'b0110, 4'b0101, 1'b1);
    def_op(4'b0000, 4'b0110, 1'b1);
    def_op(4'b1100, 4'b0111, 1'b1);
    def_op(4'b0001, 4'b1000, 1'b1);
    def_op(4'b1010, 4'b0100, 1'b0);
    def_op(4'b1000, 4'b0110, 1'b0);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_outputs", all_regd(), '0);

    // ADD R2,R2,R3
    rst = 1'b1;
    drive(32'hE0822003, 32'h0000_0100);
    tick();
    check("add_ctrl", 160'({exe_cmd, wb_en, dest}), 160'({4'b0010, 1'b1, 4'd2}));
    check("add_vals", 160'({val_rn, val_rm, pc_out}), 160'({32'd2, 32'd3, 32'h100}));

    // Bypass on R3, then the written value persists
    wb_en_in = 1'b1; wb_dest = 4'd3; wb_value = 32'h55;
    tick();
    check("bypass_rm", 160'(val_rm), 160'(32'h55));
    wb_en_in = 1'b0;
    tick();
    check("written_rm", 160'(val_rm), 160'(32'h55));

    // Conditions with Z=1
    status = 4'b0100;
    drive(32'h03A00005, 32'h104);
    tick();
    check("moveq", 160'({wb_en, imm, exe_cmd}), 160'({1'b1, 1'b1, 4'b0001}));
    drive(32'h13A00005, 32'h108);
    tick();
    check("movne", 160'({wb_en, imm, exe_cmd}), 160'({1'b0, 1'b1, 4'b0000}));

    // Memory / branch
    status = 4'b0000;
    drive(32'hE5810000, 32'h10C);
    #1;
    check("str_comb", 160'({src2, two_src}), 160'({4'd0, 1'b1}));
    tick();
    check("str", 160'({mem_w_en, mem_r_en, wb_en, exe_cmd}), 160'({1'b1, 1'b0, 1'b0, 4'b0010}));
    drive(32'hE5910000, 32'h110);
    tick();
    check("ldr", 160'({mem_r_en, wb_en, mem_w_en, s}), 160'({1'b1, 1'b1, 1'b0, 1'b1}));
    drive(32'hEA000004, 32'h114);
    tick();
    check("branch", 160'({b, signed_imm_24, exe_cmd}), 160'({1'b1, 24'h000004, 4'b0000}));

    // Freeze holds while the instruction changes
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom);
      tick();
      check("freeze_hold", 160'({b, signed_imm_24, pc_out}), 160'({1'b1, 24'h4, 32'h114}));
    end
    freeze = 1'b0; flush = 1'b1;
    tick();
    check("flush_zero", all_regd(), '0);
    flush = 1'b0; hazard = 1'b1;
    drive(32'hE0822003, 32'h118);
    tick();
    check("hazard", 160'({exe_cmd, wb_en, dest, val_rn}), 160'({4'd0, 1'b0, 4'd2, 32'd2}));
    hazard = 1'b0;
    drive(32'hE5910000, 32'h11C);
    tick();
    freeze = 1'b1; flush = 1'b1;
    drive(32'hE0822003, 32'h120);
    tick();
    check("freeze_over_flush", 160'({mem_r_en, pc_out}), 160'({1'b1, 32'h11C}));

    // Reset mid-operation beats freeze and a pending write
    rst = 1'b0; wb_en_in = 1'b1; wb_dest = 4'd4; wb_value = 32'hDEAD;
    tick();
    check("midreset_outputs", all_regd(), '0);
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; wb_en_in = 1'b0;
    drive(32'hE0834004, 32'h124);
    tick();
    check("midreset_regs", 160'({val_rn, val_rm}), 160'({32'd3, 32'd4}));

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      instruction = $urandom;
      if ($urandom_range(0, 3) != 0) instruction[31:28] = 4'hE;
      pc_in    = $urandom;
      status   = 4'($urandom_range(0, 15));
      freeze   = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      hazard   = ($urandom_range(0, 7) == 0);
      wb_en_in = 1'($urandom_range(0, 1));
      wb_dest  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) wb_dest = instruction[19:16];
      wb_value = $urandom;
      rst      = ($urandom_range(0, 199) != 0);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
